// File: rtl/button_conditioner.sv
// Two-key conditioner: synchroniser, per-key debounce, registered press pulses.
// Optional auto-repeat is compiled in when BUTTON_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_raw,
  output logic [1:0] button,
  output logic [1:0] level
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Two-cycle gaps between pulses of one key rely on every window being at least 2.
  if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_conditioner: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [CNT_W-1:0] cnt_r [2];
  logic [CNT_W-1:0] cnt_nxt_s [2];
  logic [1:0]       level_r;
  logic [1:0]       level_nxt_s;
  logic [1:0]       rise_s;
  logic [1:0]       pulse_s;
  logic [1:0]       button_r;

  // Polarity normalisation then two-flop synchroniser (1 = pressed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= btn_raw ^ {2{ACTIVE_LOW}};
      sync2_r <= sync1_r;
    end
  end

  // Debounce: level follows the sample only after DB_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_nxt_s[i] = level_r[i];
      cnt_nxt_s[i]   = {CNT_W{1'b0}};
      if (sync2_r[i] == level_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        level_nxt_s[i] = sync2_r[i];
        cnt_nxt_s[i]   = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  assign rise_s = level_nxt_s & ~level_r;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_r [2];
  logic [RPT_W-1:0] rpt_cnt_nxt_s [2];
  logic [1:0]       rpt_phase_r;
  logic [1:0]       rpt_phase_nxt_s;
  logic [1:0]       rpt_fire_s;

  // Repeat timer: first wait is REPEAT_DELAY, later waits REPEAT_PERIOD; only while the key stays held.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rpt_cnt_nxt_s[i]   = {RPT_W{1'b0}};
      rpt_phase_nxt_s[i] = 1'b0;
      rpt_fire_s[i]      = 1'b0;
      if (level_r[i] && level_nxt_s[i]) begin
        if (rpt_cnt_r[i] == (rpt_phase_r[i] ? PERIOD_LAST : DELAY_LAST)) begin
          rpt_fire_s[i]      = 1'b1;
          rpt_cnt_nxt_s[i]   = {RPT_W{1'b0}};
          rpt_phase_nxt_s[i] = 1'b1;
        end else begin
          rpt_cnt_nxt_s[i]   = rpt_cnt_r[i] + RPT_W'(1);
          rpt_phase_nxt_s[i] = rpt_phase_r[i];
        end
      end else begin
        rpt_cnt_nxt_s[i]   = {RPT_W{1'b0}};
        rpt_phase_nxt_s[i] = 1'b0;
        rpt_fire_s[i]      = 1'b0;
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        rpt_cnt_r[i] <= {RPT_W{1'b0}};
      end
      rpt_phase_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rpt_cnt_r[i] <= rpt_cnt_nxt_s[i];
      end
      rpt_phase_r <= rpt_phase_nxt_s;
    end
  end

  assign pulse_s = rise_s | rpt_fire_s;
`else
  assign pulse_s = rise_s;
`endif

  // Debounce state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      level_r  <= 2'b00;
      button_r <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      level_r  <= level_nxt_s;
      button_r <= pulse_s;
    end
  end

  assign button = button_r;
  assign level  = level_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB_CYCLES=4, active-low, repeat 10/3).
// Expectations follow BUTTON_AUTOREPEAT_EN so the same bench covers both builds.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] button;
  logic [1:0] level;

  int n_checks;
  int n_fail;

  button_conditioner #(
    .DB_CYCLES    (4),
    .ACTIVE_LOW   (1'b1),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .button (button),
    .level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Steps n edges with btn_raw fixed; level changes and button pulses at relative edge flip_k.
  task automatic expect_window(input string tag, input int n, input int flip_k,
                               input logic [1:0] lvl_pre, input logic [1:0] lvl_post,
                               input logic [1:0] pulse);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_lvl"}, level, (k >= flip_k) ? lvl_post : lvl_pre);
      check_val({tag, "_btn"}, button, (k == flip_k) ? pulse : 2'b00);
    end
  endtask

  initial begin
    logic [1:0] exp_lvl;
    logic [1:0] exp_btn;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    btn_raw  = 2'b11;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_lvl", level, 2'b00);
    check_val("reset_btn", button, 2'b00);
    rst = 1'b1;
    expect_window("idle", 3, 99, 2'b00, 2'b00, 2'b00);

    // Clean press on bit1, then release (no pulse on release).
    btn_raw = 2'b01;
    expect_window("press1", 8, 5, 2'b00, 2'b10, 2'b10);
    btn_raw = 2'b11;
    expect_window("rel1", 8, 5, 2'b10, 2'b00, 2'b00);

    // Bounce on bit0: low 3, high 1, then low and hold.
    btn_raw = 2'b10;
    expect_window("bnc_a", 3, 99, 2'b00, 2'b00, 2'b00);
    btn_raw = 2'b11;
    expect_window("bnc_b", 1, 99, 2'b00, 2'b00, 2'b00);
    btn_raw = 2'b10;
    expect_window("bnc_c", 6, 5, 2'b00, 2'b01, 2'b01);

    // Two-cycle glitch while pressed, then full release.
    btn_raw = 2'b11;
    expect_window("glitch", 2, 99, 2'b01, 2'b01, 2'b00);
    btn_raw = 2'b10;
    expect_window("glitch_tail", 2, 99, 2'b01, 2'b01, 2'b00);
    btn_raw = 2'b11;
    expect_window("rel0", 8, 5, 2'b01, 2'b00, 2'b00);

    // Simultaneous press and release.
    btn_raw = 2'b00;
    expect_window("both", 8, 5, 2'b00, 2'b11, 2'b11);
    btn_raw = 2'b11;
    expect_window("both_rel", 8, 5, 2'b11, 2'b00, 2'b00);

    // Reset while bit0 is held and bit1 is mid-debounce (counter at 2).
    btn_raw = 2'b10;
    expect_window("pre_rst0", 8, 5, 2'b00, 2'b01, 2'b01);
    btn_raw = 2'b00;
    expect_window("pre_rst1", 4, 99, 2'b01, 2'b01, 2'b00);
    rst = 1'b0;
    #2;
    check_val("rst_async_lvl", level, 2'b00);
    check_val("rst_async_btn", button, 2'b00);
    expect_window("rst_hold", 2, 99, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    expect_window("rst_rel", 8, 5, 2'b00, 2'b11, 2'b11);
    btn_raw = 2'b11;
    expect_window("rst_keyrel", 8, 5, 2'b11, 2'b00, 2'b00);

    // Long hold on bit1: raw release captured at edge 21, level falls at 26.
    btn_raw = 2'b01;
    for (int k = 0; k < 40; k++) begin
      if (k == 21) btn_raw = 2'b11;
      @(posedge clk);
      #1;
      exp_lvl = (k >= 5 && k < 26) ? 2'b10 : 2'b00;
      exp_btn = (k == 5) ? 2'b10 : 2'b00;
`ifdef BUTTON_AUTOREPEAT_EN
      if (k == 15 || k == 18 || k == 21 || k == 24) exp_btn = 2'b10;
`endif
      check_val("hold_lvl", level, exp_lvl);
      check_val("hold_btn", button, exp_btn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have a parameter DB_CYCLES, default 500000, giving the debounce window in clk cycles; legal range is 2 or more.
REQ-002 The block SHALL have a parameter ACTIVE_LOW, default 1; when 1, a raw pin low means pressed.
REQ-003 The block SHALL have a parameter REPEAT_DELAY, default 25000000, giving the hold time in cycles before the first auto-repeat pulse.
REQ-004 The block SHALL have a parameter REPEAT_PERIOD, default 10000000, giving the cycles between subsequent auto-repeat pulses.
REQ-005 Port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port btn_raw, input, 2 bits: asynchronous raw key pins; bit0 is down/previous, bit1 is up/next.
REQ-008 Port button, output, 2 bits: registered one-cycle press pulses that directly drive the menu selector's button input.
REQ-009 Port level, output, 2 bits: registered debounced pressed state, 1 meaning held.

Function
REQ-010 Each btn_raw bit SHALL be XORed with ACTIVE_LOW and passed through a two-flop synchroniser, giving a normalised signal s where 1 means pressed.
REQ-011 Each bit SHALL have its own stable register (level) and its own debounce counter of ceil(log2(DB_CYCLES)) bits; the two bits are fully independent.
REQ-012 Counter rules per edge:
- s == level: counter <= 0.
- s != level and counter < DB_CYCLES-1: counter increments.
- s != level and counter == DB_CYCLES-1: level <= s and counter <= 0.
REQ-013 Any bounce back to level before the window completes SHALL reset the counter, so level flips only after DB_CYCLES consecutive differing samples.
REQ-014 Latency: if edge N is the first edge on which the first synchroniser flop captures the new raw level, level SHALL update on edge N+DB_CYCLES+1.
REQ-015 button[i] SHALL rise on the same edge on which level[i] goes 0->1 and SHALL be high for exactly one cycle.
REQ-016 No pulse SHALL be generated on release (1->0) or on glitches shorter than DB_CYCLES.
REQ-017 If both bits qualify in the same cycle, both button bits SHALL assert together; no arbitration is performed, and the downstream selector treats this as a no-op.
REQ-018 button SHALL never be high in two consecutive cycles for the same bit.

Reset
REQ-019 While rst is low, the synchroniser flops (normalised value), counters, level, button, and repeat counters SHALL all be 0, asynchronously and at any point mid-debounce.
REQ-020 A key held through reset deassertion SHALL be treated as a new press and SHALL pulse DB_CYCLES+1 edges after the first edge that captures it.

Configuration
REQ-021 Macro BUTTON_AUTOREPEAT_EN, when defined, SHALL add a per-bit repeat counter that runs while level[i] is 1.
REQ-022 With BUTTON_AUTOREPEAT_EN defined, repeat pulses SHALL occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles until release.
REQ-023 With BUTTON_AUTOREPEAT_EN defined, release or reset SHALL clear the repeat counter.
REQ-024 With BUTTON_AUTOREPEAT_EN undefined, exactly one pulse SHALL occur per press, the repeat parameters SHALL be ignored, and no repeat logic SHALL be synthesised.

Verification (DB_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-025 Clean press: drive btn_raw[1] low before edge 10 and hold -> level[1] and button[1] rise at edge 15, button[1] falls at edge 16, and level[1] stays high.
REQ-026 Bounce: toggle btn_raw[0] low for 3 cycles, high for 1, then low and hold -> no pulse until 4 consecutive low samples, then exactly one pulse.
REQ-027 Release and glitch: after a settled press, pulse btn_raw high for 2 cycles -> no pulse and level unchanged; a full release produces no pulse.
REQ-028 Simultaneous press: both bits pressed before the same edge -> button is 2'b11 for one cycle.
REQ-029 Reset: assert rst mid-debounce (counter at 2) -> all outputs are 0 immediately; with the key still held, a pulse occurs 5 edges after the first capturing edge following release.
REQ-030 Auto-repeat: with BUTTON_AUTOREPEAT_EN defined and a key held -> pulses at T, T+10, T+13, T+16, and no further pulses after release; with the macro undefined -> a single pulse at T.
